// File: rtl/mux_4x1_using_case_statement.sv
// Four-lane, one-output selector. The 2-bit select s steers one DATA_W-wide
// lane of the packed input a onto y. y_comb always carries the zero-latency
// selection. y is either a registered copy of it (capture enable, synchronous
// reset) or a straight wire to it, depending on REGISTERED.
// sel_onehot is a combinational one-hot decode of s.
module mux_4x1_using_case_statement #(
    parameter int                 DATA_W     = 1,
    parameter bit                 REGISTERED = 1'b1,
    parameter logic [DATA_W-1:0]  RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DATA_W-1:0]   a,
    input  logic [1:0]            s,
    input  logic                  en,
    output logic [DATA_W-1:0]     y,
    output logic [DATA_W-1:0]     y_comb,
    output logic [3:0]            sel_onehot
);

    // Full decode of s: pick the lane and build the one-hot select.
    // An unknown select propagates X on the data path and no active lane.
    always_comb begin
        y_comb     = 'x;
        sel_onehot = 4'b0000;
        case (s)
            2'b00: begin
                y_comb     = a[0*DATA_W +: DATA_W];
                sel_onehot = 4'b0001;
            end
            2'b01: begin
                y_comb     = a[1*DATA_W +: DATA_W];
                sel_onehot = 4'b0010;
            end
            2'b10: begin
                y_comb     = a[2*DATA_W +: DATA_W];
                sel_onehot = 4'b0100;
            end
            2'b11: begin
                y_comb     = a[3*DATA_W +: DATA_W];
                sel_onehot = 4'b1000;
            end
            default: begin
                y_comb     = 'x;
                sel_onehot = 4'b0000;
            end
        endcase
    end

    generate
        if (REGISTERED) begin : g_reg
            // Output register: reset wins over enable, and en=0 holds the last capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y <= RESET_VAL;
                end else if (en) begin
                    y <= y_comb;
                end
            end
        end else begin : g_comb
            // Combinational mode: clk, rst and en have no effect on y.
            assign y = y_comb;
        end
    endgenerate

endmodule

// File: tb/tb_mux_4x1_using_case_statement.sv
module tb_mux_4x1_using_case_statement;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  s;
    logic [3:0]  a1;
    logic [31:0] a8;

    logic        y_reg,  yc_reg;
    logic [3:0]  oh_reg;
    logic        y_cmb,  yc_cmb;
    logic [3:0]  oh_cmb;
    logic [7:0]  y_wide, yc_wide;
    logic [3:0]  oh_wide;
    logic        y_rv1,  yc_rv1;
    logic [3:0]  oh_rv1;

    int n_checks = 0;
    int n_errors = 0;

    logic       exp_reg;
    logic       exp_rv1;
    logic [7:0] exp_wide;

    always #5 clk = ~clk;

    mux_4x1_using_case_statement #(.DATA_W(1), .REGISTERED(1'b1), .RESET_VAL(1'b0)) u_reg (
        .clk(clk), .rst(rst), .a(a1), .s(s), .en(en),
        .y(y_reg), .y_comb(yc_reg), .sel_onehot(oh_reg));

    mux_4x1_using_case_statement #(.DATA_W(1), .REGISTERED(1'b0), .RESET_VAL(1'b0)) u_cmb (
        .clk(clk), .rst(rst), .a(a1), .s(s), .en(en),
        .y(y_cmb), .y_comb(yc_cmb), .sel_onehot(oh_cmb));

    mux_4x1_using_case_statement #(.DATA_W(8), .REGISTERED(1'b1), .RESET_VAL(8'h00)) u_wide (
        .clk(clk), .rst(rst), .a(a8), .s(s), .en(en),
        .y(y_wide), .y_comb(yc_wide), .sel_onehot(oh_wide));

    mux_4x1_using_case_statement #(.DATA_W(1), .REGISTERED(1'b1), .RESET_VAL(1'b1)) u_rv1 (
        .clk(clk), .rst(rst), .a(a1), .s(s), .en(en),
        .y(y_rv1), .y_comb(yc_rv1), .sel_onehot(oh_rv1));

    // Reference: lane k of a packed vector is bits [k*W +: W], so shift right by k*W and mask.
    function automatic logic ref_bit(input logic [3:0] av, input logic [1:0] sv);
        return 1'((av >> sv) & 4'd1);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] av, input logic [1:0] sv);
        return 8'((av >> (8 * int'(sv))) & 32'hFF);
    endfunction

    function automatic logic [3:0] ref_onehot(input logic [1:0] sv);
        return 4'(4'd1 << sv);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one vector, check the zero-latency outputs, clock it, then check the registered outputs.
    task automatic apply(input logic [3:0] av, input logic [31:0] aw, input logic [1:0] sv,
                         input logic env, input logic rstv);
        a1  = av;
        a8  = aw;
        s   = sv;
        en  = env;
        rst = rstv;
        #1;
        check("y_comb",        32'(yc_reg),  32'(ref_bit(av, sv)));
        check("comb_mode_y",   32'(y_cmb),   32'(ref_bit(av, sv)));
        check("wide_y_comb",   32'(yc_wide), 32'(ref_byte(aw, sv)));
        check("sel_onehot",    32'(oh_reg),  32'(ref_onehot(sv)));
        if (rstv) begin
            exp_reg  = 1'b0;
            exp_rv1  = 1'b1;
            exp_wide = 8'h00;
        end else if (env) begin
            exp_reg  = ref_bit(av, sv);
            exp_rv1  = ref_bit(av, sv);
            exp_wide = ref_byte(aw, sv);
        end
        @(posedge clk);
        #1;
        check("y_reg",  32'(y_reg),  32'(exp_reg));
        check("y_rv1",  32'(y_rv1),  32'(exp_rv1));
        check("y_wide", 32'(y_wide), 32'(exp_wide));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; s = 2'b00; a1 = 4'b0000; a8 = 32'h0;
        exp_reg = 1'b0; exp_rv1 = 1'b1; exp_wide = 8'h00;

        // Reset first, then walk the decode with the selected lane set.
        apply(4'b0000, 32'h0, 2'b00, 1'b1, 1'b1);
        apply(4'b0001, 32'h0, 2'b00, 1'b1, 1'b0);
        apply(4'b0010, 32'h0, 2'b01, 1'b1, 1'b0);
        apply(4'b0100, 32'h0, 2'b10, 1'b1, 1'b0);
        apply(4'b1000, 32'h0, 2'b11, 1'b1, 1'b0);

        // Unselected lanes must not leak through.
        apply(4'b0111, 32'h0, 2'b11, 1'b1, 1'b0);
        apply(4'b1110, 32'h0, 2'b00, 1'b1, 1'b0);

        // Hold with en=0, then reset beats en=1.
        apply(4'b0010, 32'h0, 2'b01, 1'b1, 1'b0);
        apply(4'b0000, 32'h0, 2'b01, 1'b0, 1'b0);
        check("hold_y_reg", 32'(y_reg), 32'd1);
        apply(4'b0000, 32'h0, 2'b01, 1'b1, 1'b1);
        check("rst_prio_y_reg", 32'(y_reg), 32'd0);

        // Wide lanes.
        for (int k = 0; k < 4; k++)
            apply(4'b0000, 32'hD4C3B2A1, 2'(k), 1'b1, 1'b0);

        // Nonzero reset value: y=0 before, mid-stream reset gives 1, then a capture of 1.
        apply(4'b0000, 32'h0, 2'b00, 1'b1, 1'b0);
        check("rv1_pre", 32'(y_rv1), 32'd0);
        apply(4'b0000, 32'h0, 2'b00, 1'b1, 1'b1);
        check("rv1_rst", 32'(y_rv1), 32'd1);
        apply(4'b0100, 32'h0, 2'b10, 1'b1, 1'b0);

        // Exhaustive combinational sweep, no clock edge between vectors.
        for (int sv = 0; sv < 4; sv++) begin
            for (int av = 0; av < 16; av++) begin
                a1 = 4'(av);
                s  = 2'(sv);
                #1;
                check("sweep_comb_y", 32'(y_cmb),  32'(ref_bit(4'(av), 2'(sv))));
                check("sweep_y_comb", 32'(yc_reg), 32'(ref_bit(4'(av), 2'(sv))));
            end
        end
        @(negedge clk);

        // Randomized traffic with occasional reset and enable drops.
        apply(4'b0000, 32'h0, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            apply(4'($urandom), $urandom, 2'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
